// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if
//   Groups the decode-side issue/operand signals and the forwarding/stall
//   results of hazard_forward_unit into one bundle.
//
//   Issue handshake: issue_valid is the producer's valid and !stall acts as the
//   consumer's ready. An instruction is accepted into stage 1 on a rising edge
//   only when issue_valid=1, stall=0 and flush=0. A stalled instruction must be
//   held unchanged by decode until stall drops.
//
//   master : decode side (drives issue/operand info, reads results)
//   slave  : hazard_forward_unit
interface hazard_forward_unit_if #(
  parameter int REG_BITS = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                     flush;
  logic                     issue_valid;
  logic [REG_BITS-1:0]      issue_dst;
  logic                     issue_we;
  logic                     issue_is_load;
  logic [NSRC*REG_BITS-1:0] src_reg;
  logic [NSRC-1:0]          src_used;
  logic [NSRC*SEL_W-1:0]    fwd_sel;
  logic                     stall;
  logic [15:0]              stall_count;

  modport master (
    output flush, issue_valid, issue_dst, issue_we, issue_is_load,
    output src_reg, src_used,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  flush, issue_valid, issue_dst, issue_we, issue_is_load,
    input  src_reg, src_used,
    output fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Tracks DEPTH in-flight pipeline stages (stage 1 = EX ... stage DEPTH = WB)
//   and, for every source operand of the instruction in decode, selects the
//   youngest in-flight producer to forward from, or requests a stall when that
//   producer is a load whose data is not available yet.
//
// Ports
//   clock    : single clock, all state on the rising edge
//   reset_n  : asynchronous active-low reset, clears stage valids and counter
//   bus      : hazard_forward_unit_if.slave
//                flush        - kill every in-flight entry on the next edge
//                issue_*      - decode instruction description
//                src_reg/used - NSRC operands, operand i at [i*REG_BITS +: REG_BITS]
//                fwd_sel      - per operand: 0 = register file, k = stage k
//                stall        - hold decode, bubble into stage 1
//                stall_count  - saturating count of stalled cycles
module hazard_forward_unit #(
  parameter int REG_BITS   = 5,
  parameter int NSRC       = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2
) (
  input logic               clock,
  input logic               reset_n,
  hazard_forward_unit_if.slave bus
);

  localparam int SEL_W = $clog2(DEPTH + 1);

  // Stage entries, index k = stage k.
  logic [DEPTH:1]      vld_q, vld_d;
  logic [DEPTH:1]      we_q, we_d;
  logic [DEPTH:1]      ld_q, ld_d;
  logic [REG_BITS-1:0] dst_q [1:DEPTH];
  logic [REG_BITS-1:0] dst_d [1:DEPTH];
  logic [15:0]         cnt_q, cnt_d;

  logic [NSRC*SEL_W-1:0] fwd_sel_w;
  logic [NSRC-1:0]       stall_req;
  logic                  stall_w;

  // ---------------------------------------------------------------------------
  // Forwarding select / stall request per operand.
  // Stages are scanned from oldest to youngest so the last hit recorded is the
  // youngest producer; older producers of the same register are shadowed.
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_sel_w = '0;
    stall_req = '0;
    for (int i = 0; i < NSRC; i++) begin
      logic [REG_BITS-1:0] src;
      logic                hit;
      logic                hit_ready;
      logic [SEL_W-1:0]    hit_stage;
      src       = bus.src_reg[i*REG_BITS +: REG_BITS];
      hit       = 1'b0;
      hit_ready = 1'b0;
      hit_stage = '0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (vld_q[k] && we_q[k] && (dst_q[k] == src)) begin
          hit       = 1'b1;
          hit_stage = SEL_W'(k);
          // A load only has its data once it has reached LOAD_READY.
          hit_ready = !ld_q[k] || (k >= LOAD_READY);
        end
      end
      // Register 0 is hard-wired, and unused operands never need data.
      if (bus.src_used[i] && (src != '0) && hit) begin
        if (hit_ready) begin
          fwd_sel_w[i*SEL_W +: SEL_W] = hit_stage;
        end else begin
          stall_req[i] = 1'b1;
        end
      end
    end
  end

  // A flush kills the decode instruction too, so it can never stall.
  assign stall_w = bus.issue_valid && (|stall_req) && !bus.flush;

  // ---------------------------------------------------------------------------
  // Stage advance. Payload fields shift every cycle; only valid decides
  // whether an entry is live, so bubbles and flushes touch valid alone.
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_d    = vld_q;
    we_d     = we_q;
    ld_d     = ld_q;
    dst_d    = dst_q;
    vld_d[1] = bus.issue_valid && !stall_w;
    we_d[1]  = bus.issue_we;
    ld_d[1]  = bus.issue_is_load;
    dst_d[1] = bus.issue_dst;
    for (int k = 2; k <= DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      we_d[k]  = we_q[k-1];
      ld_d[k]  = ld_q[k-1];
      dst_d[k] = dst_q[k-1];
    end
    if (bus.flush) begin
      vld_d = '0;
    end
  end

  // Saturating stall counter; flush only matters through stall itself.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_w && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      we_q  <= '0;
      ld_q  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= '0;
      end
      cnt_q <= 16'd0;
    end else begin
      vld_q <= vld_d;
      we_q  <= we_d;
      ld_q  <= ld_d;
      for (int k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= dst_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  // With reset low every valid is already clear, so selects and stall are 0.
  assign bus.fwd_sel     = fwd_sel_w;
  assign bus.stall       = stall_w;
  assign bus.stall_count = cnt_q;

endmodule
